// File: rtl/neg_pkg.sv
// Shared types for the iterative complement unit: operation modes, FSM states
// and the mode-to-(invert, carry-in) decode used when an operand is accepted.
package neg_pkg;

  typedef enum logic [1:0] {
    MODE_NOT  = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic inv;
    logic cin;
  } ctrl_t;

  // Every mode reduces to "optionally invert, then add 0 or 1".
  function automatic ctrl_t mode_ctrl(mode_e mode, logic msb);
    ctrl_t c;
    c = '0;
    unique case (mode)
      MODE_NOT:  begin c.inv = 1'b1; c.cin = 1'b0; end
      MODE_NEG:  begin c.inv = 1'b1; c.cin = 1'b1; end
      MODE_ABS:  begin c.inv = msb;  c.cin = msb;  end
      MODE_PASS: begin c.inv = 1'b0; c.cin = 1'b0; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/negate_chunk.sv
// One CHUNK-bit slice of the complement datapath: y = (inv ? ~x : x) + cin,
// with the carry out of the slice returned separately.
module negate_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] y,
  output logic             cout
);

  logic [CHUNK-1:0] opnd;
  logic [CHUNK:0]   sum;

  assign opnd      = inv ? ~x : x;
  assign sum       = {1'b0, opnd} + {{CHUNK{1'b0}}, cin};
  assign {cout, y} = sum;

endmodule

// File: rtl/iterative_negator.sv
// Multi-cycle NOT/NEG/ABS/PASS unit rippling the carry CHUNK bits per cycle.
// Define NEG_OVF_DETECT_EN to flag NEG/ABS of the most-negative operand on out_ovf.
module iterative_negator
  import neg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("iterative_negator: WIDTH must be a multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               inv_q, inv_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   res_q, res_d;

  ctrl_t              acc_ctrl;
  logic               accept;
  logic               last_chunk;
  logic [CHUNK-1:0]   chunk_y;
  logic               chunk_cout;
  logic [WIDTH-1:0]   work_next;

  assign acc_ctrl   = mode_ctrl(mode_e'(in_mode), in_data[WIDTH-1]);
  assign accept     = in_valid && (state_q == ST_IDLE);
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_data   = res_q;

  // The working register rotates right by one chunk per cycle: the slice
  // always reads the low chunk and its result re-enters at the top, so after
  // N cycles the full result sits in place without any variable indexing.
  negate_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (work_q[CHUNK-1:0]),
    .inv  (inv_q),
    .cin  (carry_q),
    .y    (chunk_y),
    .cout (chunk_cout)
  );

  if (N == 1) begin : g_single
    assign work_next = chunk_y;
  end else begin : g_multi
    assign work_next = {chunk_y, work_q[WIDTH-1:CHUNK]};
  end

  // NOTE: combinational logic uses blocking '=' and gives every output a
  // default first, so no path through the case leaves a value held (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    work_d  = work_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = acc_ctrl.inv;
          carry_d = acc_ctrl.cin;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d  = work_next;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_chunk) begin
          res_d   = work_next;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      res_q   <= res_d;
    end
  end

  // NOTE: the working register is intentionally not reset; it is always
  // loaded on accept before the datapath reads it.
  always_ff @(posedge clock) begin
    work_q <= work_d;
  end

`ifdef NEG_OVF_DETECT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = ((in_mode == MODE_NEG) || (in_mode == MODE_ABS)) && (in_data == MOST_NEG);
    end else if ((state_q == ST_DONE) && out_ready) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_iterative_negator.sv
// Scoreboard bench for iterative_negator (WIDTH=32, CHUNK=8): directed corner
// cases, backpressure, mid-operation reset and randomized operations.
module tb_iterative_negator;
  import neg_pkg::*;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
`ifdef NEG_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data   = '0;
  logic [1:0]       in_mode   = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  exp_t sb[$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   cyc         = 0;
  int   acc_cyc     = 0;
  bit   prev_valid  = 1'b0;
  bit   rand_bp     = 1'b0;
  bit   force_ready = 1'b1;

  iterative_negator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain two's-complement arithmetic on the whole word.
  function automatic exp_t model(mode_e m, logic [31:0] x);
    exp_t e;
    case (m)
      MODE_NOT: e.data = ~x;
      MODE_NEG: e.data = 32'd0 - x;
      MODE_ABS: e.data = ($signed(x) < 0) ? 32'd0 - x : x;
      default:  e.data = x;
    endcase
    e.ovf = OVF_EN && ((m == MODE_NEG) || (m == MODE_ABS)) && (x == 32'h8000_0000);
    return e;
  endfunction

  // Monitor: latency on every rising out_valid, data/ovf on every handshake.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) check("latency", 32'(cyc - acc_cyc), 32'(N + 1));
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic send(mode_e m, logic [31:0] d);
    int waited = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    sb.push_back(model(m, d));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_drain(int budget);
    int w = 0;
    while (sb.size() != 0 && w < budget) begin
      @(negedge clock);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   w;
    exp_t held;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);

    // Directed corner cases.
    send(MODE_NOT,  32'h0000_00FF); wait_drain(50);
    send(MODE_NEG,  32'h0000_0001); wait_drain(50);
    send(MODE_NEG,  32'hFFFF_FFFF); wait_drain(50);
    send(MODE_ABS,  32'hFFFF_FFFB); wait_drain(50);
    send(MODE_ABS,  32'h0000_0007); wait_drain(50);
    send(MODE_PASS, 32'h1234_5678); wait_drain(50);
    send(MODE_NEG,  32'h8000_0000); wait_drain(50);
    send(MODE_ABS,  32'h8000_0000); wait_drain(50);
    send(MODE_NEG,  32'h0000_0000); wait_drain(50);
    send(MODE_ABS,  32'h0000_0000); wait_drain(50);
    send(MODE_NOT,  32'h0000_0000); wait_drain(50);
    send(MODE_PASS, 32'h8000_0000); wait_drain(50);

    // Backpressure: result held, no second accept while in_valid stays high.
    @(negedge clock);
    force_ready = 1'b0;
    @(posedge clock);
    held = model(MODE_ABS, 32'h8000_0005);
    send(MODE_ABS, 32'h8000_0005);
    in_valid = 1'b1;
    in_mode  = MODE_PASS;
    in_data  = 32'hDEAD_BEEF;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(negedge clock);
      check("bp_data_stable", out_data, held.data);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    force_ready = 1'b1;
    in_valid    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    check("bp_single_accept", 32'(sb.size()), 32'd0);

    // Reset during the second BUSY cycle abandons the operation.
    send(MODE_NEG, 32'h0000_1234);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clock);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    send(MODE_NEG, 32'h0000_0002);
    wait_drain(50);

    // Randomized operations with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 7))
        0:       d = 32'h0000_0000;
        1:       d = 32'h8000_0000;
        2:       d = 32'hFFFF_FFFF;
        3:       d = 32'h7FFF_FFFF;
        default: d = $urandom;
      endcase
      send(mode_e'($urandom_range(0, 3)), d);
    end
    wait_drain(500);
    rand_bp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
